// File: rtl/parser_pkg.sv
// parser_pkg: shared widths, tag layout, meta layout and slicer state encoding
package parser_pkg;
  localparam int HEAD_WIDTH = 128;
  localparam int META_WIDTH = 64;
  localparam int TAG_WIDTH = 16;
  localparam int TAG_VALID_BIT = 0;
  localparam int TAG_START_BIT = 1;
  localparam int TAG_TAIL_BIT = 2;
  localparam int TAG_SHIFT_BIT = 3;
  localparam int TAG_OFF_LSB = 4;
  localparam int TAG_OFF_W = 8;
  localparam int BCNT_W = $clog2(HEAD_WIDTH / 8) + 1;
  localparam int META_LEN_W = 16;
  localparam int META_PORT_W = 8;
  localparam int META_SEQ_W = 16;
  localparam int META_PAD_W = META_WIDTH - META_LEN_W - META_PORT_W - META_SEQ_W;
  typedef enum logic [2:0] {ST_IDLE, ST_COLLECT, ST_EMIT, ST_PAYLOAD, ST_GAP} slicer_state_e;
  function automatic logic [TAG_WIDTH-1:0] mk_tag(logic v, logic s, logic t, logic [TAG_OFF_W-1:0] off);
    logic [TAG_WIDTH-1:0] r;
    r = '0;
    r[TAG_VALID_BIT] = v;
    r[TAG_START_BIT] = s;
    r[TAG_TAIL_BIT] = t;
    r[TAG_SHIFT_BIT] = 1'b0;
    r[TAG_OFF_LSB +: TAG_OFF_W] = off;
    return r;
  endfunction
endpackage

// File: rtl/parser_pay_reg.sv
// parser_pay_reg: one-entry valid/ready register on the payload path
module parser_pay_reg
  import parser_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [HEAD_WIDTH-1:0] wr_data,
  input  logic                  wr_eop,
  input  logic [BCNT_W-1:0]     wr_bytes,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [HEAD_WIDTH-1:0] rd_data,
  output logic                  rd_eop,
  output logic [BCNT_W-1:0]     rd_bytes
);
  assign wr_ready = !rd_valid || rd_ready;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_eop <= 1'b0;
      rd_bytes <= '0;
    end else if (wr_ready) begin
      rd_valid <= wr_valid;
      if (wr_valid) begin
        rd_data <= wr_data;
        rd_eop <= wr_eop;
        rd_bytes <= wr_bytes;
      end
    end
  end
endmodule

// File: rtl/parser_head_slicer.sv
// parser_head_slicer: buffers packet head beats and emits them as a gap-free tagged head burst plus meta, payload forwarded behind
module parser_head_slicer
  import parser_pkg::*;
#(
  parameter int         HEAD_SLICE_MAX = 4,
  parameter int         GAP_CYCLES = 1,
  parameter logic [7:0] PORT_ID = 8'd0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [HEAD_WIDTH-1:0]           i_data,
  input  logic                            i_sop,
  input  logic                            i_eop,
  input  logic [BCNT_W-1:0]               i_bytes,
  input  logic [15:0]                     i_pkt_len,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
  output logic                            o_pay_valid,
  input  logic                            i_pay_ready,
  output logic [HEAD_WIDTH-1:0]           o_pay_data,
  output logic                            o_pay_eop,
  output logic [BCNT_W-1:0]               o_pay_bytes,
  output logic                            o_drop
);
  localparam int CW = $clog2(HEAD_SLICE_MAX + 1);
  localparam int IW = HEAD_SLICE_MAX > 1 ? $clog2(HEAD_SLICE_MAX) : 1;
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TAG_OFF_W-1:0] FULL_OFF = TAG_OFF_W'(HEAD_WIDTH / 8 - 1);
  localparam logic [TAG_OFF_W-1:0] META_OFF = TAG_OFF_W'(META_WIDTH / 8 - 1);
  localparam slicer_state_e DONE_ST = GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
  slicer_state_e state_q;
  logic [HEAD_WIDTH-1:0] slot_q [HEAD_SLICE_MAX];
  logic [CW-1:0] cnt_q, idx_q;
  logic ended_q, drop_q, last, pay_wr_ready;
  logic [TAG_OFF_W-1:0] eop_off_q, beat_off;
  logic [META_LEN_W-1:0] len_q;
  logic [META_SEQ_W-1:0] seq_q;
  logic [GW-1:0] gap_q;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q;
  logic [META_WIDTH+TAG_WIDTH-1:0] meta_q;
  assign beat_off = i_bytes == '0 ? FULL_OFF : TAG_OFF_W'(i_bytes - BCNT_W'(1));
  assign last = idx_q == cnt_q - CW'(1);
  assign o_ready = i_rst_n && (state_q == ST_IDLE || state_q == ST_COLLECT || (state_q == ST_PAYLOAD && pay_wr_ready));
  assign o_head = head_q;
  assign o_meta = meta_q;
  assign o_drop = drop_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < HEAD_SLICE_MAX; k++) slot_q[k] <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      ended_q <= 1'b0;
      eop_off_q <= '0;
      len_q <= '0;
      seq_q <= '0;
      gap_q <= '0;
      drop_q <= 1'b0;
      head_q <= '0;
      meta_q <= '0;
    end else begin
      drop_q <= 1'b0;
      head_q <= '0;
      meta_q <= '0;
      case (state_q)
        ST_IDLE: if (i_valid) begin
          if (i_sop) begin
            slot_q[0] <= i_data;
            cnt_q <= CW'(1);
            idx_q <= '0;
            len_q <= i_pkt_len;
            ended_q <= i_eop;
            eop_off_q <= beat_off;
            state_q <= (i_eop || HEAD_SLICE_MAX == 1) ? ST_EMIT : ST_COLLECT;
          end else drop_q <= 1'b1;
        end
        ST_COLLECT: if (i_valid) begin
          slot_q[IW'(cnt_q)] <= i_data;
          cnt_q <= cnt_q + CW'(1);
          ended_q <= i_eop;
          eop_off_q <= beat_off;
          if (i_eop || cnt_q == CW'(HEAD_SLICE_MAX - 1)) state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          head_q <= {slot_q[IW'(idx_q)], mk_tag(1'b1, idx_q == '0, last, (last && ended_q) ? eop_off_q : FULL_OFF)};
          if (idx_q == '0) begin
            meta_q <= {len_q, PORT_ID, seq_q, {META_PAD_W{1'b0}}, mk_tag(1'b1, 1'b1, 1'b1, META_OFF)};
            seq_q <= seq_q + 1'b1;
          end
          idx_q <= idx_q + CW'(1);
          gap_q <= '0;
          if (last) state_q <= ended_q ? DONE_ST : ST_PAYLOAD;
        end
        ST_PAYLOAD: if (i_valid && pay_wr_ready && i_eop) begin
          gap_q <= '0;
          state_q <= DONE_ST;
        end
        ST_GAP: begin
          gap_q <= gap_q + GW'(1);
          if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  parser_pay_reg u_pay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_valid(i_valid && state_q == ST_PAYLOAD),
    .wr_ready(pay_wr_ready),
    .wr_data (i_data),
    .wr_eop  (i_eop),
    .wr_bytes(i_bytes),
    .rd_valid(o_pay_valid),
    .rd_ready(i_pay_ready),
    .rd_data (o_pay_data),
    .rd_eop  (o_pay_eop),
    .rd_bytes(o_pay_bytes)
  );
endmodule
